// File: rtl/dqn_pkg.sv
// Shared codes for the 9-5-4 DQN datapath: step/controller codes and the
// backward sequencer state encoding.
package dqn_pkg;

  localparam logic [3:0] STEP_IDLE   = 4'd0;
  localparam logic [3:0] STEP_FWD_Z2 = 4'd1;
  localparam logic [3:0] STEP_FWD_A2 = 4'd2;
  localparam logic [3:0] STEP_FWD_Z3 = 4'd3;
  localparam logic [3:0] STEP_FWD_A3 = 4'd4;
  localparam logic [3:0] STEP_FWD_Q  = 4'd5;
  localparam logic [3:0] STEP_REWARD = 4'd6;
  localparam logic [3:0] STEP_DELTA3 = 4'd7;
  localparam logic [3:0] STEP_DELTA2 = 4'd8;
  localparam logic [3:0] STEP_GRAD   = 4'd9;

  localparam logic [3:0] CTRL_IDLE = 4'd0;
  localparam logic [3:0] CTRL_FWD  = 4'd1;
  localparam logic [3:0] CTRL_BWD  = 4'd2;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CAPTURE  = 3'd1;
  localparam logic [2:0] ST_S_REWARD = 3'd2;
  localparam logic [2:0] ST_S_DELTA3 = 3'd3;
  localparam logic [2:0] ST_S_DELTA2 = 3'd4;
  localparam logic [2:0] ST_S_GRAD   = 3'd5;
  localparam logic [2:0] ST_UPDATE   = 3'd6;
  localparam logic [2:0] ST_FINISH   = 3'd7;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    CAPTURE  = ST_CAPTURE,
    S_REWARD = ST_S_REWARD,
    S_DELTA3 = ST_S_DELTA3,
    S_DELTA2 = ST_S_DELTA2,
    S_GRAD   = ST_S_GRAD,
    UPDATE   = ST_UPDATE,
    FINISH   = ST_FINISH
  } bwd_state_t;

  // Wide enough for both the stage dwell (<=15) and the ack timeout (<=255).
  localparam int TIMER_W = 8;

endpackage

// File: rtl/backward_sequencer_stage_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module stage_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/backward_sequencer.sv
// Sequences one backward pass of the DQN datapath, then hands gradients to
// the weight-update block over a req/ack handshake.
module backward_sequencer
  import dqn_pkg::*;
#(
  parameter int STAGE_CYCLES = 2,
  parameter int UPD_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             fwd_valid,
  input  logic [1:0]       act_in,
  input  logic [3:0]       st_in,
  input  logic [3:0]       st1_in,
  input  logic             upd_ack,
  output logic [3:0]       step,
  output logic [3:0]       controller,
  output logic [1:0]       act,
  output logic [3:0]       st,
  output logic [3:0]       st1,
  output logic             busy,
  output logic             grad_valid,
  output logic             upd_req,
  output logic             done,
  output logic             err_timeout,
  output logic [CNT_W-1:0] pass_count
);

  localparam logic [TIMER_W-1:0] DWELL_LOAD   = TIMER_W'(STAGE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(UPD_TIMEOUT - 1);

  bwd_state_t       state_d, state_q;
  logic [3:0]       step_d, step_q, controller_d, controller_q;
  logic [1:0]       act_d, act_q;
  logic [3:0]       st_d, st_q, st1_d, st1_q;
  logic             busy_d, busy_q, grad_valid_d, grad_valid_q;
  logic             upd_req_d, upd_req_q, done_d, done_q, err_d, err_q;
  logic [CNT_W-1:0] pass_count_d, pass_count_q;
  logic             timer_load, timer_tc;
  logic [TIMER_W-1:0] timer_val;

  stage_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .tc       (timer_tc)
  );

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    controller_d = controller_q;
    act_d        = act_q;
    st_d         = st_q;
    st1_d        = st1_q;
    busy_d       = busy_q;
    grad_valid_d = grad_valid_q;
    upd_req_d    = upd_req_q;
    done_d       = 1'b0;
    err_d        = err_q;
    pass_count_d = pass_count_q;
    timer_load   = 1'b0;
    timer_val    = DWELL_LOAD;

    unique case (state_q)
      IDLE: begin
        if (start && fwd_valid) begin
          act_d        = act_in;
          st_d         = st_in;
          st1_d        = st1_in;
          busy_d       = 1'b1;
          controller_d = CTRL_BWD;
          state_d      = CAPTURE;
        end
      end
      CAPTURE: begin
        step_d     = STEP_REWARD;
        timer_load = 1'b1;
        state_d    = S_REWARD;
      end
      S_REWARD: begin
        if (timer_tc) begin
          step_d     = STEP_DELTA3;
          timer_load = 1'b1;
          state_d    = S_DELTA3;
        end
      end
      S_DELTA3: begin
        if (timer_tc) begin
          step_d     = STEP_DELTA2;
          timer_load = 1'b1;
          state_d    = S_DELTA2;
        end
      end
      S_DELTA2: begin
        if (timer_tc) begin
          step_d     = STEP_GRAD;
          timer_load = 1'b1;
          state_d    = S_GRAD;
        end
      end
      S_GRAD: begin
        if (timer_tc) begin
          grad_valid_d = 1'b1;
          upd_req_d    = 1'b1;
          timer_load   = 1'b1;
          timer_val    = TIMEOUT_LOAD;
          state_d      = UPDATE;
        end
      end
      UPDATE: begin
        // Ack is checked first so it wins over a timeout in the same cycle.
        if (upd_ack || timer_tc) begin
          err_d        = err_q | ~upd_ack;
          done_d       = 1'b1;
          pass_count_d = pass_count_q + CNT_W'(1);
          grad_valid_d = 1'b0;
          busy_d       = 1'b0;
          upd_req_d    = 1'b0;
          step_d       = STEP_IDLE;
          controller_d = CTRL_IDLE;
          state_d      = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      step_q       <= STEP_IDLE;
      controller_q <= CTRL_IDLE;
      act_q        <= '0;
      st_q         <= '0;
      st1_q        <= '0;
      busy_q       <= 1'b0;
      grad_valid_q <= 1'b0;
      upd_req_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      pass_count_q <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      controller_q <= controller_d;
      act_q        <= act_d;
      st_q         <= st_d;
      st1_q        <= st1_d;
      busy_q       <= busy_d;
      grad_valid_q <= grad_valid_d;
      upd_req_q    <= upd_req_d;
      done_q       <= done_d;
      err_q        <= err_d;
      pass_count_q <= pass_count_d;
    end
  end

  assign step        = step_q;
  assign controller  = controller_q;
  assign act         = act_q;
  assign st          = st_q;
  assign st1         = st1_q;
  assign busy        = busy_q;
  assign grad_valid  = grad_valid_q;
  assign upd_req     = upd_req_q;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign pass_count  = pass_count_q;

endmodule

// File: tb/tb_backward_sequencer.sv
// Directed bench for backward_sequencer; a second instance with CNT_W=2
// shares all inputs so the pass counter wrap can be observed.
module tb_backward_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, fwd_valid = 1'b0, upd_ack = 1'b0;
  logic [1:0]  act_in = '0;
  logic [3:0]  st_in = '0, st1_in = '0;

  logic [3:0]  step, controller, st, st1;
  logic [1:0]  act;
  logic        busy, grad_valid, upd_req, done, err_timeout;
  logic [15:0] pass_count;

  logic [3:0]  step2, controller2, st2, st12;
  logic [1:0]  act2;
  logic        busy2, grad_valid2, upd_req2, done2, err_timeout2;
  logic [1:0]  pass_count2;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_steps [8] = '{4'd6, 4'd6, 4'd7, 4'd7, 4'd8, 4'd8, 4'd9, 4'd9};

  always #5 clk = ~clk;

  backward_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .fwd_valid(fwd_valid),
    .act_in(act_in), .st_in(st_in), .st1_in(st1_in), .upd_ack(upd_ack),
    .step(step), .controller(controller), .act(act), .st(st), .st1(st1),
    .busy(busy), .grad_valid(grad_valid), .upd_req(upd_req), .done(done),
    .err_timeout(err_timeout), .pass_count(pass_count)
  );

  backward_sequencer #(.CNT_W(2)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .fwd_valid(fwd_valid),
    .act_in(act_in), .st_in(st_in), .st1_in(st1_in), .upd_ack(upd_ack),
    .step(step2), .controller(controller2), .act(act2), .st(st2), .st1(st12),
    .busy(busy2), .grad_valid(grad_valid2), .upd_req(upd_req2), .done(done2),
    .err_timeout(err_timeout2), .pass_count(pass_count2)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a one-cycle start; returns on the negedge after it was sampled.
  task automatic applyStimulus(input logic [1:0] a, input logic [3:0] s,
                               input logic [3:0] s1, input logic fv);
    tick();
    act_in    = a;
    st_in     = s;
    st1_in    = s1;
    fwd_valid = fv;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitUpdReq(input string tag);
    for (int i = 0; i < 30 && upd_req !== 1'b1; i++) tick();
    checkOutput(tag, upd_req, 1'b1);
  endtask

  initial begin
    int n;
    int dones;

    #1;
    checkOutput("rst_step", step, 4'd0);
    checkOutput("rst_ctrl", controller, 4'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_count", pass_count, 16'd0);
    tick();
    rst = 1'b1;

    // start without fwd_valid is dropped
    applyStimulus(2'd1, 4'd3, 4'd5, 1'b0);
    checkOutput("gate_busy", busy, 1'b0);
    checkOutput("gate_act", act, 2'd0);
    tick();
    checkOutput("gate_step", step, 4'd0);
    checkOutput("gate_busy2", busy, 1'b0);

    // nominal pass, ack one cycle after upd_req
    applyStimulus(2'd2, 4'd0, 4'd1, 1'b1);
    checkOutput("cap_busy", busy, 1'b1);
    checkOutput("cap_ctrl", controller, 4'd2);
    checkOutput("cap_step", step, 4'd0);
    checkOutput("cap_act", act, 2'd2);
    checkOutput("cap_st", st, 4'd0);
    checkOutput("cap_st1", st1, 4'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("step_seq", step, exp_steps[i]);
      checkOutput("ctrl_bwd", controller, 4'd2);
      checkOutput("no_req_early", upd_req, 1'b0);
    end
    tick();
    checkOutput("upd_req", upd_req, 1'b1);
    checkOutput("grad_valid", grad_valid, 1'b1);
    checkOutput("upd_step", step, 4'd9);
    upd_ack = 1'b1;
    tick();
    upd_ack = 1'b0;
    checkOutput("done_c11", done, 1'b1);
    checkOutput("nom_count", pass_count, 16'd1);
    checkOutput("wrap_1", pass_count2, 2'd1);
    checkOutput("nom_err", err_timeout, 1'b0);
    checkOutput("fin_req", upd_req, 1'b0);
    checkOutput("fin_busy", busy, 1'b0);
    checkOutput("fin_gv", grad_valid, 1'b0);
    checkOutput("fin_step", step, 4'd0);
    checkOutput("fin_ctrl", controller, 4'd0);
    tick();
    checkOutput("done_pulse", done, 1'b0);

    // second start in S_DELTA2 plus input churn while busy
    applyStimulus(2'd1, 4'd5, 4'd9, 1'b1);
    dones = 0;
    for (int c = 2; c <= 25; c++) begin
      tick();
      if (c == 6) begin
        checkOutput("in_delta2", step, 4'd8);
        start  = 1'b1;
        act_in = 2'd0;
        st_in  = 4'hC;
        st1_in = 4'hA;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) dones++;
      upd_ack = upd_req;
    end
    upd_ack = 1'b0;
    checkOutput("one_done", dones, 32'd1);
    checkOutput("hold_act", act, 2'd1);
    checkOutput("hold_st", st, 4'd5);
    checkOutput("hold_st1", st1, 4'd9);
    checkOutput("pass2_count", pass_count, 16'd2);
    checkOutput("wrap_2", pass_count2, 2'd2);
    checkOutput("pass2_busy", busy, 1'b0);

    // ack never comes
    applyStimulus(2'd1, 4'd2, 4'd3, 1'b1);
    waitUpdReq("to_req_seen");
    n = 0;
    for (int i = 0; i < 200 && upd_req === 1'b1; i++) begin
      n++;
      tick();
    end
    checkOutput("to_req_cycles", n, 32'd64);
    checkOutput("to_done", done, 1'b1);
    checkOutput("to_err", err_timeout, 1'b1);
    checkOutput("to_count", pass_count, 16'd3);
    checkOutput("wrap_3", pass_count2, 2'd3);
    tick();

    // good pass after a timeout keeps the sticky flag
    applyStimulus(2'd0, 4'd1, 4'd2, 1'b1);
    waitUpdReq("p4_req_seen");
    upd_ack = 1'b1;
    tick();
    upd_ack = 1'b0;
    checkOutput("p4_done", done, 1'b1);
    checkOutput("sticky_err", err_timeout, 1'b1);
    checkOutput("p4_count", pass_count, 16'd4);
    checkOutput("wrap_0", pass_count2, 2'd0);

    rst = 1'b0;
    #1;
    checkOutput("rst_err_clr", err_timeout, 1'b0);
    tick();
    rst = 1'b1;

    // ack on the last UPDATE cycle beats the timeout
    applyStimulus(2'd3, 4'd4, 4'd5, 1'b1);
    waitUpdReq("tie_req_seen");
    repeat (63) tick();
    checkOutput("tie_req_held", upd_req, 1'b1);
    checkOutput("tie_no_err_yet", err_timeout, 1'b0);
    upd_ack = 1'b1;
    tick();
    upd_ack = 1'b0;
    checkOutput("tie_done", done, 1'b1);
    checkOutput("tie_err", err_timeout, 1'b0);
    checkOutput("tie_count", pass_count, 16'd1);
    tick();

    // asynchronous reset during S_GRAD
    applyStimulus(2'd2, 4'd6, 4'd7, 1'b1);
    for (int i = 0; i < 30 && step !== 4'd9; i++) tick();
    checkOutput("ar_in_grad", step, 4'd9);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("ar_step", step, 4'd0);
    checkOutput("ar_ctrl", controller, 4'd0);
    checkOutput("ar_busy", busy, 1'b0);
    checkOutput("ar_act", act, 2'd0);
    checkOutput("ar_st", st, 4'd0);
    checkOutput("ar_count", pass_count, 16'd0);
    tick();
    checkOutput("ar_done", done, 1'b0);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    checkOutput("ar_no_done", dones, 32'd0);
    checkOutput("ar_idle_busy", busy, 1'b0);
    checkOutput("ar_count_after", pass_count, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
